// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-side signals of the memory arbiter
// The master modport is the arbiter's view; slave is the core/memory side that drives it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [BE_W-1:0]   ls_be;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory between fetch and load/store
// Load/store has priority, but a waiting fetch wins after MAX_DSTREAK consecutive load/store grants.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       owner_ls;
    logic [3:0] streak;
    logic       arb_cycle;
    logic       ls_wins;
    logic       if_wins;

    // Arbitrating on the response cycle is what removes the IDLE bubble between transactions.
    always_comb begin
        arb_cycle = (state == IDLE) || ((state == RESP) && bus.mem_rvalid);
        ls_wins   = bus.ls_req && !(bus.if_req && (streak == STREAK_MAX));
        if_wins   = bus.if_req && !ls_wins;
    end

    assign bus.if_gnt    = bus.mem_gnt    && (state == REQ)  && !owner_ls;
    assign bus.ls_gnt    = bus.mem_gnt    && (state == REQ)  &&  owner_ls;
    assign bus.if_rvalid = bus.mem_rvalid && (state == RESP) && !owner_ls;
    assign bus.ls_rvalid = bus.mem_rvalid && (state == RESP) &&  owner_ls;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            owner_ls      <= 1'b0;
            streak        <= 4'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_be    <= {BE_W{1'b0}};
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.mem_gnt) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                    end
                end
                default: begin
                    if (arb_cycle) begin
                        if (ls_wins) begin
                            state         <= REQ;
                            owner_ls      <= 1'b1;
                            bus.mem_req   <= 1'b1;
                            bus.busy      <= 1'b1;
                            bus.mem_we    <= bus.ls_we;
                            bus.mem_addr  <= bus.ls_addr;
                            bus.mem_wdata <= bus.ls_wdata;
                            bus.mem_be    <= bus.ls_be;
                            if (!bus.if_req)
                                streak <= 4'd0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + 4'd1;
                        end else if (if_wins) begin
                            state         <= REQ;
                            owner_ls      <= 1'b0;
                            bus.mem_req   <= 1'b1;
                            bus.busy      <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= {DATA_W{1'b0}};
                            bus.mem_be    <= {BE_W{1'b1}};
                            streak        <= 4'd0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            streak   <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, split-transaction memory between the fetch port (Q1, read-only) and the load/store port (Q4, read/write).
- Sits between the core pipeline and the unified memory.
- Keeps at most one transaction outstanding.
- Gives the load/store port priority, with a bounded streak so fetch is never starved.

Parameters:
- ADDR_W, 32, address width of both ports and the memory side.
- DATA_W, 32, data width. Byte enables are DATA_W/8 bits.
- MAX_DSTREAK, 4, maximum consecutive load/store grants while a fetch request is waiting. Range 1..15.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  fetch request. Held with i_if_addr until o_if_gnt.
- i_if_addr  in  ADDR_W  fetch address, word-aligned.
- o_if_gnt  out  1  fetch request accepted by memory (one-cycle pulse).
- o_if_rvalid  out  1  fetch data valid (one-cycle pulse).
- o_if_rdata  out  DATA_W  fetch data, qualified by o_if_rvalid.
- i_ls_req  in  1  load/store request. Held with all i_ls_* inputs until o_ls_gnt.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_addr  in  ADDR_W  load/store address.
- i_ls_wdata  in  DATA_W  store data.
- i_ls_be  in  DATA_W/8  store byte enables.
- o_ls_gnt  out  1  load/store request accepted by memory.
- o_ls_rvalid  out  1  load data valid, or store completed.
- o_ls_rdata  out  DATA_W  load data. Don't-care for stores.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- o_mem_be  out  DATA_W/8  memory byte enables. All ones for fetch.
- i_mem_gnt  in  1  memory accepts the request this cycle.
- i_mem_rvalid  in  1  memory response. Issued for reads and for writes.
- i_mem_rdata  in  DATA_W  memory read data.
- o_busy  out  1  high when the state is not IDLE.

Behaviour:
- FSM states are IDLE, REQ and RESP. An owner register records IF or LS.
- Reset (asynchronous, active-low, from any state, including mid-transaction):
  - State goes to IDLE, owner to IF, streak counter to 0.
  - All outputs are 0. o_mem_* address, data and byte enables are 0.
  - The in-flight transaction is dropped; requesters reissue after reset.
  - Any i_mem_rvalid that arrives after reset is ignored.
- Arbitration happens in IDLE, and in RESP on the cycle i_mem_rvalid is high:
  - LS wins if i_ls_req=1, unless i_if_req=1 and streak==MAX_DSTREAK. In that case IF wins.
  - Otherwise IF wins if i_if_req=1.
  - With no request, the FSM goes to (or stays in) IDLE.
- A win registers owner, addr, we, wdata and be into the o_mem_* registers and moves the FSM to REQ. o_mem_req rises the next cycle, so request-to-o_mem_req latency is 1 cycle.
- For a fetch, o_mem_we=0 and o_mem_be is all ones.
- REQ state:
  - o_mem_req=1 and o_mem_* are held stable until i_mem_gnt.
  - On i_mem_gnt, o_mem_req drops the next cycle and the FSM goes to RESP.
  - o_if_gnt = i_mem_gnt & REQ & owner==IF. This is combinational, so the gnt pulse lands in the same cycle as i_mem_gnt. o_ls_gnt is the same with owner==LS.
- RESP state:
  - o_if_rvalid = i_mem_rvalid & RESP & owner==IF; o_ls_rvalid likewise with owner==LS.
  - o_if_rdata and o_ls_rdata are combinational pass-throughs of i_mem_rdata.
  - i_mem_rvalid is ignored in IDLE and REQ.
  - Same-cycle i_mem_gnt and i_mem_rvalid is impossible by protocol, because rvalid follows gnt by at least 1 cycle.
- Throughput: with the memory granting immediately and answering 1 cycle later, one transaction completes every 2 cycles, with no IDLE bubble between back-to-back transactions.
- Streak counter (4 bits):
  - On an LS win while i_if_req=1: increments, saturating at MAX_DSTREAK.
  - On an IF win, or in any arbitration cycle with i_if_req=0: clears to 0.
- Stores complete like loads: a single o_ls_rvalid pulse. Store data is never forwarded.
- A requester that drops its req after the arbiter has latched it still gets its transaction completed, including the gnt and rvalid pulses. Upstream must not do this.
- A simultaneous new request and an rvalid in RESP is the normal back-to-back case. The response is delivered and the new request is latched in the same cycle.

Test Plan:
- Single fetch:
  - Stimulus: i_if_req=1, addr 0x0000_0010; memory grants immediately and returns rvalid 1 cycle later with 0x0000_0093.
  - Required: o_mem_req at cycle 1, o_if_gnt at cycle 1, o_if_rvalid=1 with rdata 0x93 at cycle 2, o_ls_* silent.
- Store priority over fetch:
  - Stimulus: i_if_req and i_ls_req rise together; LS is a store to addr 0x100, wdata 0xDEADBEEF, be 4'b0011.
  - Required: the memory sees we=1, addr 0x100, be 0011 first; the fetch is issued right after the store's rvalid.
- Starvation bound:
  - Stimulus: MAX_DSTREAK=4; i_if_req and i_ls_req held continuously high.
  - Required: grant sequence is LS, LS, LS, LS, IF, LS, LS, LS, LS, IF, and so on.
- Memory back-pressure:
  - Stimulus: LS load; i_mem_gnt held low for 5 cycles.
  - Required: o_mem_req and address stable all 5 cycles; o_ls_gnt exactly once; o_ls_rvalid exactly once.
- Reset mid-transaction:
  - Stimulus: assert i_rst_n=0 in RESP; release it; memory then sends a stray rvalid.
  - Required: all outputs 0 immediately; FSM in IDLE; the stray rvalid produces no o_*_rvalid.
- Stray response:
  - Stimulus: i_mem_rvalid pulsed while in IDLE.
  - Required: no rvalid on either port; o_busy stays 0.
